// File: rtl/avalon_mem_pattern_master.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_mem_pattern_master
//  Purpose  : Avalon-MM memory self-test initiator. Fills a word window with a
//             generated pattern, reads it back, and reports pass/fail, error
//             count and first failing address.
//             Define MEM_PATTERN_LFSR_EN for a Galois-LFSR pattern instead of
//             the default seed+index pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_mem_pattern_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              avm_clken
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]      c_LAT_LAST = 2'(READ_LATENCY - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_num;
    logic [ADDR_W:0]   r_idx;
    logic [31:0]       r_seed;
    logic [31:0]       r_pat;
    logic [1:0]        r_lat;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_pass;

    logic              w_cs;
    logic              w_wr;
    logic              w_rd;
    logic              w_last;
    logic              w_lat_done;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_seed_eff;
    logic [31:0]       w_pat_next;

`ifdef MEM_PATTERN_LFSR_EN
    // A zero seed would lock the LFSR at zero forever.
    assign w_seed_eff = (seed == 32'h0) ? 32'h1 : seed;
    assign w_pat_next = {1'b0, r_pat[31:1]} ^ (r_pat[0] ? 32'hA300_0000 : 32'h0);
`else
    assign w_seed_eff = seed;
    assign w_pat_next = r_pat + 32'h1;
`endif

    assign w_addr     = r_base + r_idx[ADDR_W-1:0];
    assign w_last     = (r_idx == (r_num - c_ONE));
    assign w_lat_done = (r_lat == c_LAT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cs         = 1'b0;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (num_words == '0) ? S_FIN : S_WR;
                end
            end
            S_WR: begin
                w_cs = 1'b1;
                w_wr = 1'b1;
                if (!avm_waitrequest && w_last) begin
                    w_next_state = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_cs = 1'b1;
                w_rd = 1'b1;
                if (!avm_waitrequest) begin
                    w_next_state = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (w_lat_done) begin
                    w_next_state = w_last ? S_FIN : S_RD_REQ;
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base           <= '0;
            r_num            <= '0;
            r_idx            <= '0;
            r_seed           <= '0;
            r_pat            <= '0;
            r_lat            <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base           <= base_addr;
                        r_num            <= num_words;
                        r_seed           <= w_seed_eff;
                        r_pat            <= w_seed_eff;
                        r_idx            <= '0;
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        r_pass           <= 1'b0;
                    end
                end
                S_WR: begin
                    if (!avm_waitrequest) begin
                        if (w_last) begin
                            // Read phase regenerates the pattern from the latched seed.
                            r_idx <= '0;
                            r_pat <= r_seed;
                        end else begin
                            r_idx <= r_idx + c_ONE;
                            r_pat <= w_pat_next;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        r_lat <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (w_lat_done) begin
                        if (avm_readdata != r_pat) begin
                            r_err_count <= r_err_count + c_ONE;
                            if (r_err_count == '0) begin
                                r_first_err_addr <= w_addr;
                            end
                        end
                        r_idx <= r_idx + c_ONE;
                        r_pat <= w_pat_next;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_FIN: begin
                    r_pass <= (r_err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (r_state == S_WR) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
    assign done           = (r_state == S_FIN);
    // Result is visible in the done cycle itself, then held in r_pass.
    assign pass           = (r_state == S_FIN) ? (r_err_count == '0) : r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign avm_chipselect = w_cs;
    assign avm_write      = w_wr;
    assign avm_read       = w_rd;
    assign avm_byteenable = w_cs ? 4'hF : 4'h0;
    assign avm_address    = w_cs ? w_addr : '0;
    assign avm_writedata  = w_wr ? r_pat : '0;
    assign avm_clken      = ~reset;

endmodule
`default_nettype wire
